// File: rtl/mem_line_responder.sv
// Fixed-latency 128-bit line memory with one-cycle ready pulse and turnaround state.
// Optional sticky protocol checker enabled by defining MEM_PROTO_CHECK_EN (adds proto_err).
module mem_line_responder #(
    parameter int unsigned LATENCY    = 4,
    parameter int unsigned DEPTH_LOG2 = 8
) (
    input  logic         clk,
    input  logic         proc_reset,
    input  logic         mem_read,
    input  logic         mem_write,
    input  logic [27:0]  mem_addr,
    input  logic [127:0] mem_wdata,
    output logic [127:0] mem_rdata,
    output logic         mem_ready
`ifdef MEM_PROTO_CHECK_EN
    ,
    output logic         proto_err
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    localparam logic [7:0] LAST = 8'(LATENCY - 1);

    state_t               state_q, state_d;
    logic [7:0]           cnt_q, cnt_d;
    logic                 is_wr_q, is_wr_d;
    logic [27:0]          addr_q, addr_d;
    logic [127:0]         wdata_q, wdata_d;
    logic [127:0]         rdata_q, rdata_d;
    logic                 ready_q, ready_d;
    logic                 commit;
    logic [DEPTH_LOG2-1:0] idx;

    logic [127:0] mem_q [2**DEPTH_LOG2];

    // Upper captured address bits only matter to the checker; they alias in the array.
    logic unused_addr_bits;
    assign unused_addr_bits = ^addr_q;

    assign idx = addr_q[DEPTH_LOG2-1:0];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        is_wr_d = is_wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        ready_d = 1'b0;
        commit  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (mem_write) begin
                    is_wr_d = 1'b1;
                    addr_d  = mem_addr;
                    wdata_d = mem_wdata;
                    cnt_d   = '0;
                    state_d = S_BUSY;
                end else if (mem_read) begin
                    is_wr_d = 1'b0;
                    addr_d  = mem_addr;
                    cnt_d   = '0;
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                if (cnt_q == LAST) begin
                    commit  = 1'b1;
                    ready_d = 1'b1;
                    state_d = S_DONE;
                    if (!is_wr_q) begin
                        rdata_d = mem_q[idx];
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge proc_reset) begin
        if (proc_reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            is_wr_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            is_wr_q <= is_wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            ready_q <= ready_d;
        end
    end

    // Array has no reset; a write pending when reset hits is simply never committed.
    always_ff @(posedge clk) begin
        if (commit && is_wr_q && !proc_reset) begin
            mem_q[idx] <= wdata_q;
        end
    end

    assign mem_rdata = rdata_q;
    assign mem_ready = ready_q;

`ifdef MEM_PROTO_CHECK_EN
    logic err_q, err_d;

    always_comb begin
        err_d = err_q;
        if (state_q == S_IDLE && mem_read && mem_write) begin
            err_d = 1'b1;
        end
        if (state_q == S_BUSY && (mem_read || mem_write)) begin
            if ((mem_write != is_wr_q) || (mem_addr != addr_q) ||
                (is_wr_q && (mem_wdata != wdata_q))) begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge proc_reset) begin
        if (proc_reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign proto_err = err_q;
`endif

endmodule

// File: doc/mem_line_responder.md
# mem_line_responder

Memory-side responder for the 128-bit line interface used by the instruction and data caches. It accepts line read and line write requests and services them from an internal line array after a fixed, parameterised latency. It answers each request with a one-cycle `mem_ready` pulse. It sits below a cache as the slow-memory model in system simulation, and as the synthesisable on-chip backing store.

## Interface
- `LATENCY`, default 4: cycles from request capture to the `mem_ready` pulse; legal range 1..255.
- `DEPTH_LOG2`, default 8: log2 of the number of 128-bit lines stored.

- `clk`  input  1  single clock; all state changes on the rising edge.
- `proc_reset`  input  1  asynchronous, active-high reset.
- `mem_read`  input  1  line read request, level, held by the cache until it sees `mem_ready`.
- `mem_write`  input  1  line write request, level, held likewise.
- `mem_addr`  input  28  line address; only bits [DEPTH_LOG2-1:0] index the array, and upper bits alias.
- `mem_wdata`  input  128  write line; word 0 is bits [31:0].
- `mem_rdata`  output  128  read line; registered.
- `mem_ready`  output  1  completion pulse; registered.
- `proto_err`  output  1  sticky protocol error flag; present only with `MEM_PROTO_CHECK_EN`.

## Operation
- **States:**
  - IDLE: waiting for a request.
  - BUSY: counting latency.
  - DONE: ready pulse plus turnaround.
- **IDLE:**
  - If `mem_write` is high, capture `mem_addr` and `mem_wdata` as a write, clear the counter and go to BUSY.
  - Otherwise, if `mem_read` is high, capture `mem_addr` as a read and go to BUSY.
  - Otherwise stay in IDLE.
- **Both requests high:** write wins and the read is ignored. This is a protocol violation.
- **BUSY:**
  - The counter increments every cycle.
  - When the counter reaches LATENCY-1, go to DONE on the next edge.
  - On that edge, a write commits the captured line to the array; a read loads `mem_rdata` from the array at the captured index.
- **Request inputs during BUSY:** ignored. The captured values are used. If the request drops, the transaction still completes and still pulses ready.
- **DONE:**
  - `mem_ready`=1 for exactly this cycle.
  - Unconditionally return to IDLE; the request is not sampled in DONE.
  - This turnaround absorbs the cache's one-cycle delay in dropping its request.
  - It also lets a write-back be followed directly by a refill request, which is sampled in the following IDLE cycle.
- **`mem_rdata`:** holds its value until the next read commits. Writes do not alter it.
- **Read after write to the same index:** returns the new data, because the write committed earlier.
- **Array contents:** not reset; contents are undefined until written.
- **Reset, including mid-transaction:**
  - State returns to IDLE and the counter to 0.
  - `mem_ready`=0 and `mem_rdata`=0.
  - `proto_err`=0.
  - A pending write is discarded and never committed.

## Timing
- Request high at edge E0 in IDLE means it is captured at E0.
- Array write or `mem_rdata` load happens at edge E0+LATENCY.
- `mem_ready` is high during the cycle between E0+LATENCY and E0+LATENCY+1.
- Earliest next capture is at E0+LATENCY+2.
- The minimum request-to-request spacing is therefore LATENCY+2 cycles.
- LATENCY=1 gives BUSY lasting one cycle.

## Configuration
- `MEM_PROTO_CHECK_EN` defined:
  - Adds the `proto_err` port and its checker.
  - `proto_err` is set, and stays set until reset, when `mem_read` and `mem_write` are both high in IDLE.
  - It is also set when, during BUSY, the request kind, `mem_addr` or (for writes) `mem_wdata` differs from the captured value while a request is still asserted.
  - Dropping the request in BUSY does not set the flag.
- `MEM_PROTO_CHECK_EN` undefined: no `proto_err` port and no checker logic; functional behaviour is identical.

## Test plan
- **Write then read back:** LATENCY=4, write addr 28'h0000012 with data 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210. Required:
  - `mem_ready` pulses 4 cycles after capture, for 1 cycle.
  - A following read of 28'h0000012 gives that value on `mem_rdata` in the read's ready cycle.
- **Aliasing:** with DEPTH_LOG2=8, write 128'hA5 (zero-extended) to 28'h0000105. A read of 28'h0000005 returns 128'hA5.
- **Cache-style hold and back-to-back:**
  - Write-back held until ready, then a read request raised the cycle after ready.
  - Exactly one write and one read occur.
  - The second capture happens at the first IDLE cycle after DONE; there is no duplicate write.
- **Both requests high:** `mem_read`=`mem_write`=1 to addr 3 with data 128'h1. The array holds 128'h1 at index 3 and `mem_rdata` is unchanged. With `MEM_PROTO_CHECK_EN`, `proto_err`=1.
- **Reset mid-write:** assert `proc_reset` 2 cycles into a write of 128'hFF to addr 7. Required:
  - `mem_ready` does not pulse and outputs go to 0 immediately.
  - A later read of addr 7 returns the prior contents, not 128'hFF.
- **Checker, address change:** with `MEM_PROTO_CHECK_EN`, change `mem_addr` during BUSY of a read. `proto_err` rises the next cycle, and the read still returns the originally captured index.
